// File: rtl/codecaudio_sample_pacer.sv
// codecaudio_sample_pacer: Avalon-MM sample FIFO released one word per timer tick,
// serialized MSB-first to the codec DAC pins with a low-water interrupt.
module codecaudio_sample_pacer #(
    parameter int DEPTH    = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    input  logic        tick,
    output logic        dac_bclk,
    output logic        dac_lrck,
    output logic        dac_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(BCLK_DIV);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [8:0]    level_q, level_d, thresh_q, thresh_d;
    logic [1:0]    ctrl_q, ctrl_d;
    logic          und_q, und_d, ovf_q, ovf_d, late_q, late_d;
    logic [DW-1:0] div_q, div_d;
    logic [4:0]    hcnt_q, hcnt_d;
    logic          bclk_q, bclk_d, irq_q, irq_d;
    logic [15:0]   shreg_q, shreg_d, readdata_q, readdata_d;
    logic          wr, push, push_ok, pop, start, wrap, done, stat_wr;

    always_comb begin
        wr      = chipselect & ~write_n;
        push    = wr && address == 2'd0;
        stat_wr = wr && address == 2'd1;
        wrap    = state_q == SHIFT && div_q == DW'(BCLK_DIV - 1);
        done    = wrap && hcnt_q == 5'd31;
        // The final wrap of a frame doubles as an idle slot so ticks can run back-to-back.
        start   = tick && ctrl_q[0] && (state_q == IDLE || done);
        pop     = start && level_q != 9'd0;
        push_ok = push && (level_q != 9'(DEPTH) || pop);
        wptr_d  = wptr_q + AW'(push_ok);
        rptr_d  = rptr_q + AW'(pop);
        level_d = level_q + 9'(push_ok) - 9'(pop);
        ctrl_d   = (wr && address == 2'd2) ? writedata[1:0] : ctrl_q;
        thresh_d = (wr && address == 2'd3) ? writedata[8:0] : thresh_q;
        und_d  = (start && !pop) | (und_q & ~stat_wr);
        ovf_d  = (push && !push_ok) | (ovf_q & ~stat_wr);
        late_d = (tick && ctrl_q[0] && state_q == SHIFT && !done) | (late_q & ~stat_wr);
        state_d = state_q;
        div_d   = div_q;
        hcnt_d  = hcnt_q;
        bclk_d  = bclk_q;
        shreg_d = shreg_q;
        if (start) begin
            state_d = SHIFT;
            div_d   = '0;
            hcnt_d  = '0;
            bclk_d  = 1'b0;
            shreg_d = pop ? mem_q[rptr_q] : 16'd0;
        end else if (state_q == SHIFT) begin
            div_d = wrap ? '0 : div_q + 1'b1;
            if (wrap) begin
                hcnt_d  = hcnt_q + 1'b1;
                bclk_d  = ~bclk_q;
                shreg_d = bclk_q ? {shreg_q[14:0], 1'b0} : shreg_q;
                state_d = done ? IDLE : SHIFT;
            end
        end
        readdata_d = address == 2'd1 ? {state_q == SHIFT, und_q, ovf_q, late_q, 3'b0, level_q} :
                     address == 2'd2 ? {14'd0, ctrl_q} :
                     address == 2'd3 ? {7'd0, thresh_q} : 16'd0;
        irq_d = ctrl_q[1] && level_q <= thresh_q;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= writedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            thresh_q   <= '0;
            ctrl_q     <= '0;
            und_q      <= 1'b0;
            ovf_q      <= 1'b0;
            late_q     <= 1'b0;
            div_q      <= '0;
            hcnt_q     <= '0;
            bclk_q     <= 1'b0;
            irq_q      <= 1'b0;
            shreg_q    <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            thresh_q   <= thresh_d;
            ctrl_q     <= ctrl_d;
            und_q      <= und_d;
            ovf_q      <= ovf_d;
            late_q     <= late_d;
            div_q      <= div_d;
            hcnt_q     <= hcnt_d;
            bclk_q     <= bclk_d;
            irq_q      <= irq_d;
            shreg_q    <= shreg_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
    assign dac_bclk = bclk_q;
    assign dac_lrck = state_q == SHIFT;
    assign dac_data = dac_lrck & shreg_q[15];
endmodule

// File: tb/tb_codecaudio_sample_pacer.sv
// tb_codecaudio_sample_pacer: directed and randomized checks of the sample pacer
// against a queue-based model of the FIFO, flags and serial frame.
module tb_codecaudio_sample_pacer;
    localparam int DEPTH    = 16;
    localparam int BCLK_DIV = 4;
    localparam int FRAME    = 32 * BCLK_DIV;

    logic        clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1, tick = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [15:0] writedata = 16'd0, readdata;
    logic        irq, dac_bclk, dac_lrck, dac_data;
    int          checks = 0, errors = 0;

    logic [15:0] q[$];
    bit          m_und, m_ovf, m_late;
    logic [1:0]  m_ctrl;
    logic [8:0]  m_thresh;

    codecaudio_sample_pacer #(.DEPTH(DEPTH), .BCLK_DIV(BCLK_DIV)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
        .tick(tick), .dac_bclk(dac_bclk), .dac_lrck(dac_lrck), .dac_data(dac_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_status();
        return {1'b0, m_und, m_ovf, m_late, 3'b0, 9'(q.size())};
    endfunction

    function automatic logic m_irq();
        return m_ctrl[1] && (q.size() <= int'(m_thresh));
    endfunction

    task automatic m_reset();
        q.delete();
        m_und = 0; m_ovf = 0; m_late = 0; m_ctrl = 0; m_thresh = 0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        chipselect = 1; write_n = 0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 0; write_n = 1;
        case (a)
            2'd0: if (q.size() == DEPTH) m_ovf = 1; else q.push_back(d);
            2'd1: begin m_und = 0; m_ovf = 0; m_late = 0; end
            2'd2: m_ctrl = d[1:0];
            default: m_thresh = d[8:0];
        endcase
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] v);
        @(negedge clk);
        address = a;
        @(negedge clk);
        v = readdata;
    endtask

    task automatic chk_status(input string tag);
        logic [15:0] v;
        rd(2'd1, v);
        chk(tag, v, m_status());
    endtask

    task automatic chk_irq(input string tag);
        @(negedge clk);
        chk(tag, irq, m_irq());
    endtask

    // One full frame: optional late tick at cycle 50, optional tick on the final edge
    // (chain) and optional tick already issued by the previous frame (preticked).
    task automatic frame(input bit late50, input bit chain, input bit preticked);
        logic [15:0] exp, cap;
        int bad;
        cap = 0;
        bad = 0;
        if (!preticked) begin
            @(negedge clk);
            tick = 1;
        end
        if (q.size() > 0) exp = q.pop_front();
        else begin
            exp = 0;
            m_und = 1;
        end
        @(negedge clk);
        tick = 0;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            if (dac_lrck !== 1'b1) bad++;
            if (dac_bclk !== ((c % (2 * BCLK_DIV)) >= BCLK_DIV)) bad++;
            if (c % (2 * BCLK_DIV) == BCLK_DIV) cap[15 - c / (2 * BCLK_DIV)] = dac_data;
            if (c == 1) chk("irq_after_pop", irq, m_irq());
            tick = (late50 && c == 50) || (chain && c == FRAME - 1);
        end
        if (late50) m_late = 1;
        chk("frame_data", cap, exp);
        chk("frame_bclk_lrck", bad, 0);
        if (!chain) begin
            @(negedge clk);
            chk("idle_pins", {dac_lrck, dac_bclk, dac_data}, 3'b000);
        end
    endtask

    initial begin
        logic [15:0] v;
        m_reset();
        repeat (3) @(negedge clk);
        chk("reset_pins", {dac_bclk, dac_lrck, dac_data, irq}, 4'b0000);
        chk("reset_readdata", readdata, 16'd0);
        reset = 0;
        chk_status("reset_status");
        rd(2'd2, v); chk("reset_control", v, 16'd0);
        rd(2'd3, v); chk("reset_thresh", v, 16'd0);

        wr(2'd0, 16'hA5C3);
        rd(2'd0, v); chk("data_reads_zero", v, 16'd0);
        wr(2'd2, 16'd1);
        frame(0, 0, 0);
        chk_status("status_after_a5c3");

        frame(0, 0, 0);
        chk_status("underrun_set");
        wr(2'd1, 16'd0);
        chk_status("underrun_cleared");

        for (int i = 0; i < DEPTH + 1; i++) wr(2'd0, 16'($urandom));
        chk_status("overflow_level16");
        for (int i = 0; i < DEPTH; i++) frame(0, 0, 0);
        wr(2'd1, 16'd0);
        chk_status("drained");

        for (int i = 0; i < 3; i++) wr(2'd0, 16'($urandom));
        frame(1, 1, 0);
        frame(0, 0, 1);
        chk_status("late_set");
        wr(2'd1, 16'd0);
        frame(0, 0, 0);
        chk_status("after_late_frame");

        wr(2'd3, 16'd2);
        wr(2'd2, 16'd3);
        for (int i = 0; i < 4; i++) begin
            wr(2'd0, 16'($urandom));
            chk_irq("irq_push");
        end
        for (int i = 0; i < 4; i++) begin
            frame(0, 0, 0);
            chk_irq("irq_drain");
        end
        for (int i = 0; i < 3; i++) begin
            wr(2'd0, 16'($urandom));
            chk_irq("irq_refill");
        end

        wr(2'd3, 16'h01FF);
        rd(2'd2, v);
        @(negedge clk); tick = 1;
        @(negedge clk); tick = 0;
        repeat (40) @(negedge clk);
        chk("midframe_active", dac_lrck, 1'b1);
        reset = 1;
        #1;
        chk("midreset_pins", {dac_bclk, dac_lrck, dac_data, irq}, 4'b0000);
        chk("midreset_readdata", readdata, 16'd0);
        repeat (2) @(negedge clk);
        reset = 0;
        m_reset();
        chk_status("post_reset_status");
        rd(2'd2, v); chk("post_reset_control", v, 16'd0);

        wr(2'd3, 16'($urandom_range(0, 5)));
        wr(2'd2, 16'd3);
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0, 1: begin wr(2'd0, 16'($urandom)); chk_irq("rand_irq_push"); end
                2: frame(0, 0, 0);
                3: chk_status("rand_status");
                default: begin wr(2'd1, 16'd0); chk_status("rand_clear"); end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/codecaudio_sample_pacer.md
# codecaudio_sample_pacer

Avalon-MM slave that buffers 16-bit DAC samples written by the CPU and releases one sample per tick pulse from the interval timer (its timeout event), serializing it MSB-first to the audio codec DAC pins. It sits directly downstream of the sample-rate timer and upstream of the codec. It raises a low-water interrupt so software can refill the buffer before it underruns.

## Interface
- DEPTH, 16, FIFO entries; power of two, 4..256
- BCLK_DIV, 4, clk cycles per half bclk period; >= 2
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  16  write data
- readdata  out  16  registered read data
- irq  out  1  low-water interrupt, registered
- tick  in  1  one-cycle sample-rate pulse from the timer
- dac_bclk  out  1  codec bit clock
- dac_lrck  out  1  frame strobe, high for the whole frame
- dac_data  out  1  serial sample data

One clock; reset is asynchronous and active-high. All outputs are 0 while reset is asserted.

## Operation
- Register map (wr = chipselect & ~write_n):
  - 0 DATA: write pushes writedata; reads as 0.
  - 1 STATUS: read {busy[15], underrun[14], overflow[13], late[12], 3'b0, level[8:0]}. Any write clears bits 14..12.
  - 2 CONTROL[1:0]: bit0 enable, bit1 irq_en. Reads zero-extended.
  - 3 THRESH[8:0]: low-water mark. Reads zero-extended.
- Reset values: CONTROL=0, THRESH=0, flags=0, FIFO empty, level=0.
- FIFO: push on a DATA write. If level==DEPTH and no pop occurs that cycle, the push is dropped and overflow is set. When push and pop coincide, both take effect and level is unchanged. An empty FIFO has no bypass: a pop in the same cycle as a push into empty is an underrun.
- FSM states:
  - IDLE: bclk=0, lrck=0, data=0.
  - On tick & enable in IDLE:
    - If level>0: pop the head into the 16-bit shift register.
    - Else: load 0 and set underrun.
    - Then go to SHIFT.
  - SHIFT:
    - lrck=1; data = shreg[15].
    - A divider counts 0..BCLK_DIV-1, and bclk toggles at each wrap. bclk rises mid-bit and falls at bit boundaries.
    - The shift register shifts left at each falling edge.
    - After 16 bits (32 half-periods), return to IDLE.
- A tick in SHIFT is ignored and sets late. A tick while enable=0 is ignored with no flag.
- Clearing enable mid-frame: the current frame completes, and no new frames start.
- Flag set/clear collision: a set event wins over a STATUS-write clear in the same cycle.
- irq: registered; irq <= irq_en & (level <= THRESH).
- busy = (state==SHIFT).

## Timing
- readdata: valid 1 cycle after the address is presented, as a registered mux. Read has no side effects.
- Register writes take effect on the clock edge of the write cycle. A level change from a push is visible on the next read.
- Tick at cycle T (sampled at edge T):
  - Edge T: pop/load occurs and state becomes SHIFT.
  - Cycle T+1: lrck=1, dac_data=sample[15], bclk=0.
  - Edge T+BCLK_DIV: bclk rises.
  - Edge T+2·BCLK_DIV: bclk falls and bit 14 is presented.
- Frame length: 32·BCLK_DIV cycles (128 at default). At edge T+32·BCLK_DIV the block is back in IDLE, and a new tick can be accepted on that same edge.
- irq lags the level change by 1 cycle.
- Reset mid-frame: all outputs go to 0 immediately, the FSM goes to IDLE, and FIFO contents are discarded.

## Test plan
- Push 0xA5C3, set CONTROL=1, pulse tick → dac_data shows 1010010111000011 MSB-first, each bit 8 cycles. lrck is high for 128 cycles; the bclk rising edge occurs 4 cycles into each bit. STATUS afterwards = 0x0000.
- Empty FIFO, enable=1, tick → all-zero frame transmitted; STATUS bit14=1. A STATUS write clears it.
- Push 17 words with DEPTH=16 → level=16, overflow=1, and 16 pops return the first 16 words in order.
- A tick at cycle 50 of an active frame sets late=1. The frame is unaffected, and the next tick after frame end starts normally.
- THRESH=2, irq_en=1, push 4 words, issue ticks → irq goes high 1 cycle after level reaches 2 and stays high at level 0. It drops after level rises to 3 (via pushes).
- Assert reset at cycle 40 of a frame → bclk, lrck, dac_data, irq, and readdata are 0 immediately. After release, level=0 and CONTROL=0.
